// File: rtl/lcd_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : lcd_timing_ctrl_if
// Brief  : Control/status bundle between the LCD timing controller and its user.
// Rev    : 1.0  initial release
// ============================================================================
interface lcd_timing_ctrl_if;
    logic        EN;
    logic        BTN_USER;
    logic        LCD_HSYNC;
    logic        LCD_VSYNC;
    logic        LCD_DEN;
    logic [10:0] pixel_x;
    logic [9:0]  pixel_y;
    logic        line_start;
    logic        frame_start;
    logic        pattern_sel;

    modport master (
        output EN, BTN_USER,
        input  LCD_HSYNC, LCD_VSYNC, LCD_DEN, pixel_x, pixel_y,
        input  line_start, frame_start, pattern_sel
    );

    modport slave (
        input  EN, BTN_USER,
        output LCD_HSYNC, LCD_VSYNC, LCD_DEN, pixel_x, pixel_y,
        output line_start, frame_start, pattern_sel
    );
endinterface
`default_nettype wire

// File: rtl/lcd_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module : lcd_timing_ctrl
// Brief  : RGB LCD sync/DEN/pixel-coordinate generator with frame-synchronous
//          debounced pattern select.
// Rev    : 1.0  initial release
// ============================================================================
module lcd_timing_ctrl #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12,
    parameter int DEB_CYC  = 65536
) (
    input  wire logic             XTAL_IN,
    input  wire logic             RST_N,
    lcd_timing_ctrl_if.slave      lcd
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int DEB_W   = $clog2(DEB_CYC);

    localparam logic [10:0] C_H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [9:0]  C_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] C_HS_END  = 11'(H_SYNC);
    localparam logic [10:0] C_HA_BEG  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] C_HA_END  = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  C_VS_END  = 10'(V_SYNC);
    localparam logic [9:0]  C_VA_BEG  = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  C_VA_END  = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [DEB_W-1:0] C_DEB_LAST = DEB_W'(DEB_CYC - 1);

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 1024 || DEB_CYC < 2) begin : g_param_err
            $error("lcd_timing_ctrl: timing sums exceed counter range or DEB_CYC < 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [10:0] h, h_nxt;
    logic [9:0]  v, v_nxt;
    logic        running_nxt;
    logic        h_act, v_act, den_nxt;

    logic             btn_meta, btn_sync, deb_level;
    logic [DEB_W-1:0] deb_cnt;

    always_comb begin
        state_nxt = state;
        h_nxt     = 11'd0;
        v_nxt     = 10'd0;
        case (state)
            ST_IDLE: begin
                if (lcd.EN) state_nxt = ST_RUN;
            end
            default: begin
                // Leaving only happens on the last pixel, so the wrapped counters are already 0.
                if (h == C_H_LAST && v == C_V_LAST && !lcd.EN)
                    state_nxt = ST_IDLE;
                else
                    state_nxt = lcd.EN ? ST_RUN : ST_DRAIN;
                if (h == C_H_LAST) begin
                    h_nxt = 11'd0;
                    v_nxt = (v == C_V_LAST) ? 10'd0 : v + 10'd1;
                end else begin
                    h_nxt = h + 11'd1;
                    v_nxt = v;
                end
            end
        endcase
        running_nxt = (state_nxt != ST_IDLE);
        h_act       = (h_nxt >= C_HA_BEG) && (h_nxt < C_HA_END);
        v_act       = (v_nxt >= C_VA_BEG) && (v_nxt < C_VA_END);
        den_nxt     = running_nxt && h_act && v_act;
    end

    always_ff @(posedge XTAL_IN) begin
        if (!RST_N) begin
            state           <= ST_IDLE;
            h               <= 11'd0;
            v               <= 10'd0;
            lcd.LCD_HSYNC   <= 1'b1;
            lcd.LCD_VSYNC   <= 1'b1;
            lcd.LCD_DEN     <= 1'b0;
            lcd.pixel_x     <= 11'd0;
            lcd.pixel_y     <= 10'd0;
            lcd.line_start  <= 1'b0;
            lcd.frame_start <= 1'b0;
        end else begin
            state           <= state_nxt;
            h               <= h_nxt;
            v               <= v_nxt;
            lcd.LCD_HSYNC   <= !(running_nxt && (h_nxt < C_HS_END));
            lcd.LCD_VSYNC   <= !(running_nxt && (v_nxt < C_VS_END));
            lcd.LCD_DEN     <= den_nxt;
            lcd.pixel_x     <= den_nxt ? (h_nxt - C_HA_BEG) : 11'd0;
            lcd.pixel_y     <= den_nxt ? (v_nxt - C_VA_BEG) : 10'd0;
            lcd.line_start  <= running_nxt && (h_nxt == 11'd0);
            lcd.frame_start <= running_nxt && (h_nxt == 11'd0) && (v_nxt == 10'd0);
        end
    end

    // Button: two-flop synchroniser, run-length debounce, commit on frame boundary.
    always_ff @(posedge XTAL_IN) begin
        if (!RST_N) begin
            btn_meta        <= 1'b0;
            btn_sync        <= 1'b0;
            deb_level       <= 1'b0;
            deb_cnt         <= '0;
            lcd.pattern_sel <= 1'b0;
        end else begin
            btn_meta <= lcd.BTN_USER;
            btn_sync <= btn_meta;
            if (btn_sync != deb_level) begin
                if (deb_cnt == C_DEB_LAST) begin
                    deb_level <= btn_sync;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
            if (lcd.frame_start)
                lcd.pattern_sel <= deb_level;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_timing_ctrl
// Brief  : Directed + randomized bench for lcd_timing_ctrl, scaled-down timing.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lcd_timing_ctrl;
    localparam int HA = 8, HF = 2, HS = 2, HB = 3;
    localparam int VA = 6, VF = 2, VS = 2, VB = 2;
    localparam int DEB = 16;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_timing_ctrl_if bus ();

    lcd_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .DEB_CYC(DEB)
    ) dut (
        .XTAL_IN(clk),
        .RST_N  (rst_n),
        .lcd    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a running flag and a linear position within the frame.
    bit m_on;
    int m_pos;
    bit s1, s2, deb, psel, fs_q;
    int dcnt;

    int  ncyc = 0, last_fs = 0, den_cnt = 0;
    bit  st_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit rstn, input bit en, input bit btn);
        if (!rstn) begin
            m_on = 0; m_pos = 0; s1 = 0; s2 = 0; deb = 0; dcnt = 0; psel = 0; fs_q = 0;
        end else begin
            if (fs_q) psel = deb;
            if (s2 != deb) begin
                dcnt++;
                if (dcnt == DEB) begin deb = ~deb; dcnt = 0; end
            end else begin
                dcnt = 0;
            end
            s2 = s1;
            s1 = btn;
            if (!m_on) begin
                if (en) begin m_on = 1; m_pos = 0; end
            end else if (m_pos == FRAME - 1 && !en) begin
                m_on = 0; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
            fs_q = m_on && (m_pos == 0);
        end
    endtask

    function automatic logic [25:0] model_out();
        int  h, v;
        bit  den;
        logic [10:0] x;
        logic [9:0]  y;
        h   = m_pos % HT;
        v   = m_pos / HT;
        den = m_on && h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
        x   = den ? 11'(h - HS - HB) : 11'd0;
        y   = den ? 10'(v - VS - VB) : 10'd0;
        return {!(m_on && h < HS), !(m_on && v < VS), den, x, y,
                m_on && h == 0, m_on && m_pos == 0};
    endfunction

    task automatic tick();
        logic [25:0] got;
        @(posedge clk);
        model_step(rst_n, bus.EN, bus.BTN_USER);
        #1;
        ncyc++;
        got = {bus.LCD_HSYNC, bus.LCD_VSYNC, bus.LCD_DEN, bus.pixel_x, bus.pixel_y,
               bus.line_start, bus.frame_start};
        chk("timing", 32'(got), 32'(model_out()));
        chk("pattern_sel", 32'(bus.pattern_sel), 32'(psel));
        if (!m_on) st_valid = 1'b0;
        if (bus.frame_start === 1'b1) begin
            if (st_valid) begin
                chk("frame_period", ncyc - last_fs, FRAME);
                chk("den_per_frame", den_cnt, HA * VA);
            end
            st_valid = m_on;
            last_fs  = ncyc;
            den_cnt  = 0;
        end
        if (bus.LCD_DEN === 1'b1) den_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pos(input int target);
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME + 4 && !found; i++) begin
            tick();
            found = m_on && (m_pos == target);
        end
        chk("wait_pos_reached", 32'(found), 32'd1);
    endtask

    initial begin
        int hold;
        bit found;
        rst_n = 1'b0;
        bus.EN = 1'b0;
        bus.BTN_USER = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(100);
        chk("idle_pattern_sel", 32'(bus.pattern_sel), 32'd0);
        chk("idle_hsync", 32'(bus.LCD_HSYNC), 32'd1);

        // Continuous frames, first RUN cycle is a frame start.
        bus.EN = 1'b1;
        tick();
        chk("first_frame_start", 32'(bus.frame_start), 32'd1);
        run(3 * FRAME);

        // Bounce shorter than the debounce window.
        for (int i = 0; i < 40; i++) begin
            bus.BTN_USER = ~bus.BTN_USER;
            run(5);
        end
        chk("bounce_psel", 32'(bus.pattern_sel), 32'd0);
        bus.BTN_USER = 1'b0;
        run(2 * FRAME);

        // Held press mid-frame commits only after the next frame start.
        wait_pos(FRAME / 3);
        bus.BTN_USER = 1'b1;
        found = 1'b0;
        for (int i = 0; i < FRAME + 4 && !found; i++) begin
            tick();
            found = (bus.frame_start === 1'b1);
        end
        chk("held_fs_seen", 32'(found), 32'd1);
        chk("held_psel_at_fs", 32'(bus.pattern_sel), 32'd0);
        tick();
        chk("held_psel_after_fs", 32'(bus.pattern_sel), 32'd1);

        // Drop EN mid-frame: frame drains then idles.
        wait_pos(5 * HT + 3);
        bus.EN = 1'b0;
        run(FRAME + 20);
        chk("drained_den", 32'(bus.LCD_DEN), 32'd0);

        // Drop then re-raise before frame end: no restart.
        bus.EN = 1'b1;
        wait_pos(3 * HT);
        bus.EN = 1'b0;
        wait_pos(8 * HT);
        bus.EN = 1'b1;
        run(2 * FRAME);

        // Reset mid-line.
        wait_pos(4 * HT + 7);
        rst_n = 1'b0;
        tick();
        chk("reset_den", 32'(bus.LCD_DEN), 32'd0);
        chk("reset_psel", 32'(bus.pattern_sel), 32'd0);
        rst_n = 1'b1;
        run(10);

        // Randomized EN / button / occasional reset.
        hold = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(299) == 0) bus.EN = ~bus.EN;
            if (hold == 0) begin
                bus.BTN_USER = 1'($urandom_range(1));
                hold = int'($urandom_range(40, 1));
            end
            hold--;
            rst_n = ($urandom_range(2999) != 0);
            tick();
        end
        rst_n = 1'b1;
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
